// File: rtl/rom_dl_packer_if.sv
// Bus bundle for the ROM download loader: ioctl byte stream in, toggle-handshake SDRAM write port out.
// The slave modport is the loader's view; master is the data_io/SDRAM side that drives it.
interface rom_dl_packer_if #(
  parameter int BYTES = 2,
  parameter int AW    = 23
);
  logic                 ioctl_download;
  logic [7:0]           ioctl_index;
  logic                 ioctl_wr;
  logic [24:0]          ioctl_addr;
  logic [7:0]           ioctl_dout;
  logic                 mem_req;
  logic                 mem_ack;
  logic [AW-1:0]        mem_a;
  logic [BYTES-1:0]     mem_ds;
  logic [8*BYTES-1:0]   mem_d;
  logic                 mem_we;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    output mem_req, mem_a, mem_ds, mem_d, mem_we
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    input  mem_req, mem_a, mem_ds, mem_d, mem_we
  );
endinterface

// File: rtl/rom_dl_packer.sv
// ROM download loader: packs ioctl bytes into BYTES-wide words, queues them for a toggle-handshake
// SDRAM port and sequences core reset. Optional running byte checksum under ROM_DL_CHECKSUM_EN.
//   state   | meaning
//   S_IDLE  | no matching download seen yet
//   S_LOAD  | matching download active, packing bytes
//   S_FLUSH | download ended, push partial packer word
//   S_DRAIN | wait for FIFO empty and no request outstanding
//   S_HOLD  | core held in reset for HOLD_CYCLES
//   S_DONE  | load complete, core_reset follows user_reset
module rom_dl_packer #(
  parameter int         BYTES       = 2,
  parameter int         AW          = 23,
  parameter int         DEPTH       = 4,
  parameter logic [7:0] INDEX       = 8'd0,
  parameter int         HOLD_CYCLES = 16
) (
  input  logic               clk_sys,
  input  logic               reset,
  rom_dl_packer_if.slave     bus,
  input  logic               user_reset,
  output logic               rom_loaded,
  output logic               core_reset,
  output logic               overflow
`ifdef ROM_DL_CHECKSUM_EN
  ,
  output logic [15:0]        checksum
`endif
);
  localparam int LW     = $clog2(BYTES);
  localparam int LANE_W = (LW > 0) ? LW : 1;
  localparam int DW     = 8 * BYTES;
  localparam int WW     = AW + DW + BYTES;
  localparam int PW     = $clog2(DEPTH);
  localparam int HW     = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN, S_HOLD, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [HW-1:0]       r_hold;
  logic                r_user_q;
  logic                w_flush;

  logic [AW-1:0]       r_pk_a;
  logic [DW-1:0]       r_pk_d;
  logic [BYTES-1:0]    r_pk_m;

  logic [WW-1:0]       r_fifo [DEPTH];
  logic [PW-1:0]       r_wp, r_rp;
  logic [PW:0]         r_cnt;

  logic                r_req, r_we;
  logic [AW-1:0]       r_mem_a;
  logic [DW-1:0]       r_mem_d;
  logic [BYTES-1:0]    r_mem_ds;

  logic                w_dl_match, w_acc, w_differ, w_last, w_pk_empty;
  logic [LANE_W-1:0]   w_lane;
  logic [AW-1:0]       w_waddr;
  logic [DW-1:0]       w_new_d;
  logic [BYTES-1:0]    w_new_m;
  logic                w_push_a, w_push_b, w_ok_a, w_ok_b, w_pop, w_issue;
  logic [PW:0]         w_free;
  logic [WW-1:0]       w_head;
  logic                w_unused;

  generate
    if (LW > 0) begin : g_lane
      assign w_lane = bus.ioctl_addr[LW-1:0];
    end else begin : g_nolane
      assign w_lane = '0;
    end
  endgenerate

  assign w_unused   = ^bus.ioctl_addr;
  assign w_waddr    = bus.ioctl_addr[AW+LW-1:LW];
  assign w_dl_match = bus.ioctl_download && (bus.ioctl_index == INDEX);
  assign w_acc      = w_dl_match && bus.ioctl_wr;
  assign w_pk_empty = (r_pk_m == '0);
  assign w_differ   = !w_pk_empty && (w_waddr != r_pk_a);
  assign w_last     = (w_lane == LANE_W'(BYTES - 1));

  // A new byte either merges into the current word or starts from a cleared one
  always_comb begin
    w_new_d = (w_pk_empty || w_differ) ? '0 : r_pk_d;
    w_new_m = (w_pk_empty || w_differ) ? '0 : r_pk_m;
    w_new_d[w_lane*8 +: 8] = bus.ioctl_dout;
    w_new_m = w_new_m | (BYTES'(1) << w_lane);
  end

  // Up to two pushes per cycle: the displaced old word, then the word this byte completes
  assign w_push_a = (w_acc && w_differ) || (w_flush && !w_pk_empty);
  assign w_push_b = w_acc && w_last;
  assign w_pop    = r_we && (bus.mem_ack == r_req);
  assign w_free   = (PW+1)'(DEPTH) - r_cnt + {{PW{1'b0}}, w_pop};
  assign w_ok_a   = w_push_a && (w_free != '0);
  assign w_ok_b   = w_push_b && (w_free > {{PW{1'b0}}, w_ok_a});
  assign w_head   = r_fifo[r_rp];
  assign w_issue  = !r_we && (r_cnt != '0);

  always_comb begin
    w_next  = r_state;
    w_flush = 1'b0;
    case (r_state)
      S_IDLE:  if (w_dl_match) w_next = S_LOAD;
      S_LOAD:  if (!w_dl_match) w_next = S_FLUSH;
      S_FLUSH: if (w_dl_match) w_next = S_LOAD;
               else begin
                 w_flush = 1'b1;
                 w_next  = S_DRAIN;
               end
      S_DRAIN: if (w_dl_match) w_next = S_LOAD;
               else if (r_cnt == '0 && !r_we) w_next = S_HOLD;
      S_HOLD:  if (w_dl_match) w_next = S_LOAD;
               else if (r_hold == '0) w_next = S_DONE;
      S_DONE:  if (w_dl_match) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      rom_loaded <= 1'b0;
      r_user_q   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_user_q <= user_reset;
      if (w_next == S_HOLD && r_state != S_HOLD) r_hold <= HW'(HOLD_CYCLES - 1);
      else if (r_state == S_HOLD && r_hold != '0) r_hold <= r_hold - 1'b1;
      if (r_state == S_HOLD && w_next == S_DONE) rom_loaded <= 1'b1;
    end
  end

  assign core_reset = (r_state != S_DONE) || r_user_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_pk_a <= '0;
      r_pk_d <= '0;
      r_pk_m <= '0;
    end else if (w_acc) begin
      r_pk_a <= w_waddr;
      r_pk_d <= w_last ? '0 : w_new_d;
      r_pk_m <= w_last ? '0 : w_new_m;
    end else if (w_flush) begin
      r_pk_d <= '0;
      r_pk_m <= '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_ok_a) r_fifo[r_wp] <= {r_pk_a, r_pk_d, r_pk_m};
    if (w_ok_b) r_fifo[r_wp + PW'(w_ok_a)] <= {w_waddr, w_new_d, w_new_m};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      overflow <= 1'b0;
    end else begin
      r_wp  <= r_wp + PW'(w_ok_a) + PW'(w_ok_b);
      r_rp  <= r_rp + PW'(w_pop);
      r_cnt <= r_cnt + (PW+1)'(w_ok_a) + (PW+1)'(w_ok_b) - (PW+1)'(w_pop);
      if ((w_push_a && !w_ok_a) || (w_push_b && !w_ok_b)) overflow <= 1'b1;
    end
  end

  // Head stays in the FIFO until acknowledged, so the bus holds it without a copy being lost
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_mem_a  <= '0;
      r_mem_d  <= '0;
      r_mem_ds <= '0;
    end else if (w_issue) begin
      r_req                       <= ~r_req;
      r_we                        <= 1'b1;
      {r_mem_a, r_mem_d, r_mem_ds} <= w_head;
    end else if (w_pop) begin
      r_we <= 1'b0;
    end
  end

  assign bus.mem_req = r_req;
  assign bus.mem_we  = r_we;
  assign bus.mem_a   = r_mem_a;
  assign bus.mem_d   = r_mem_d;
  assign bus.mem_ds  = r_mem_ds;

`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] r_sum;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_sum <= '0;
    else if (w_next == S_LOAD && r_state != S_LOAD) r_sum <= w_acc ? 16'(bus.ioctl_dout) : '0;
    else if (w_acc) r_sum <= r_sum + 16'(bus.ioctl_dout);
  end
  assign checksum = r_sum;
`endif
endmodule

// File: tb/tb_rom_dl_packer.sv
// Bench for rom_dl_packer: table of downloads plus hand sequences, with a request scoreboard.
module tb_rom_dl_packer;
  localparam int         BYTES = 2;
  localparam int         AW    = 23;
  localparam int         DEPTH = 4;
  localparam int         HOLD  = 16;
  localparam logic [7:0] INDEX = 8'd0;

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic user_reset = 1'b0;
  logic rom_loaded, core_reset, overflow;
`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  rom_dl_packer_if #(.BYTES(BYTES), .AW(AW)) bus();

  rom_dl_packer #(.BYTES(BYTES), .AW(AW), .DEPTH(DEPTH), .INDEX(INDEX), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus.slave), .user_reset(user_reset),
    .rom_loaded(rom_loaded), .core_reset(core_reset), .overflow(overflow)
`ifdef ROM_DL_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
    logic [1:0]    ds;
  } word_t;

  typedef struct {
    logic [7:0]        idx;
    int                nb;
    logic [3:0][24:0]  ba;
    logic [3:0][7:0]   bd;
    int                nw;
    word_t [3:0]       ew;
    logic              exp_loaded;
    logic              exp_cr;
  } vec_t;

  word_t exp_q[$];
  int    n_tests = 0, n_fail = 0, n_tog = 0, stab_err = 0, cyc = 0, last_ack_cyc = 0;
  bit    hold_ack = 1'b1;

  always @(posedge clk_sys) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Request monitor: every mem_req toggle is matched against the next expected word
  initial begin : mon
    logic  prev;
    word_t snap, e;
    logic [15:0] m;
    prev = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk_sys);
      if (reset) prev = 1'b0;
      else if (bus.mem_req !== prev) begin
        prev = bus.mem_req;
        n_tog++;
        snap = {bus.mem_a, bus.mem_d, bus.mem_ds};
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: got a=0x%0h d=0x%0h, expected no request", bus.mem_a, bus.mem_d);
        end else begin
          e = exp_q.pop_front();
          m = {{8{e.ds[1]}}, {8{e.ds[0]}}};
          check("req_a", 64'(bus.mem_a), 64'(e.a));
          check("req_ds", 64'(bus.mem_ds), 64'(e.ds));
          check("req_d", 64'(bus.mem_d & m), 64'(e.d & m));
        end
      end else if (bus.mem_we && {bus.mem_a, bus.mem_d, bus.mem_ds} !== snap) stab_err++;
    end
  end

  // SDRAM model: acknowledges three cycles after a request unless held off
  initial begin : acker
    int pend;
    pend = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (reset) begin
        bus.mem_ack = 1'b0;
        pend = 0;
      end else if (!hold_ack && bus.mem_req !== bus.mem_ack) begin
        pend++;
        if (pend >= 3) begin
          bus.mem_ack  = bus.mem_req;
          last_ack_cyc = cyc;
          pend = 0;
        end
      end else pend = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic begin_dl(input logic [7:0] idx);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    tick();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (core_reset && n < 1500) begin
      tick();
      n++;
    end
    check(name, 64'(core_reset), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  vec_t tbl[4];
  logic [1:0] cr_pat[6];

  initial begin : main
    int tog0, elapsed;
    tbl[0] = '{idx: 8'd0, nb: 4, ba: {25'd3, 25'd2, 25'd1, 25'd0}, bd: {8'h44, 8'h33, 8'h22, 8'h11},
               nw: 2, ew: {41'd0, 41'd0, {23'd1, 16'h4433, 2'b11}, {23'd0, 16'h2211, 2'b11}},
               exp_loaded: 1'b1, exp_cr: 1'b0};
    tbl[1] = '{idx: 8'd0, nb: 2, ba: {25'd0, 25'd0, 25'd6, 25'd0}, bd: {8'h00, 8'h00, 8'h66, 8'h55},
               nw: 2, ew: {41'd0, 41'd0, {23'd3, 16'h0066, 2'b01}, {23'd0, 16'h0055, 2'b01}},
               exp_loaded: 1'b1, exp_cr: 1'b0};
    tbl[2] = '{idx: 8'd0, nb: 2, ba: {25'd0, 25'd0, 25'd9, 25'd4}, bd: {8'h00, 8'h00, 8'h99, 8'h88},
               nw: 2, ew: {41'd0, 41'd0, {23'd4, 16'h9900, 2'b10}, {23'd2, 16'h0088, 2'b01}},
               exp_loaded: 1'b1, exp_cr: 1'b0};
    tbl[3] = '{idx: 8'd1, nb: 2, ba: {25'd0, 25'd0, 25'd1, 25'd0}, bd: {8'h00, 8'h00, 8'hDE, 8'hAD},
               nw: 0, ew: '0, exp_loaded: 1'b1, exp_cr: 1'b0};
    cr_pat = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};

    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    tick(2);
    check("rst_mem_req", 64'(bus.mem_req), 64'(0));
    check("rst_mem_we", 64'(bus.mem_we), 64'(0));
    check("rst_mem_bus", 64'({bus.mem_a, bus.mem_d, bus.mem_ds}), 64'(0));
    check("rst_rom_loaded", 64'(rom_loaded), 64'(0));
    check("rst_core_reset", 64'(core_reset), 64'(1));
    check("rst_overflow", 64'(overflow), 64'(0));
    reset = 1'b0;
    hold_ack = 1'b0;
    tick(2);

    // Foreign index while idle: nothing moves
    tog0 = n_tog;
    begin_dl(8'd1);
    send_byte(25'd0, 8'h12);
    send_byte(25'd1, 8'h34);
    end_dl();
    tick(20);
    check("idle_foreign_toggles", 64'(n_tog - tog0), 64'(0));
    check("idle_foreign_core_reset", 64'(core_reset), 64'(1));
    check("idle_foreign_loaded", 64'(rom_loaded), 64'(0));

    // Odd length with the last word's ack delayed; loaded only after it
    hold_ack = 1'b1;
    exp_q.push_back({23'd0, 16'hBBAA, 2'b11});
    exp_q.push_back({23'd1, 16'h00CC, 2'b01});
    begin_dl(8'd0);
    send_byte(25'd0, 8'hAA);
    send_byte(25'd1, 8'hBB);
    send_byte(25'd2, 8'hCC);
    end_dl();
    tick(40);
    check("odd_not_loaded", 64'(rom_loaded), 64'(0));
    check("odd_core_reset", 64'(core_reset), 64'(1));
    check("odd_we_pending", 64'(bus.mem_we), 64'(1));
    hold_ack = 1'b0;
    wait_done("odd_done");
    elapsed = cyc - last_ack_cyc;
    check("odd_hold_time_in_range", 64'(elapsed >= HOLD && elapsed <= HOLD + 4), 64'(1));
    check("odd_loaded", 64'(rom_loaded), 64'(1));
    check("odd_queue_empty", 64'(exp_q.size()), 64'(0));

    for (int r = 0; r < 4; r++) begin
      tog0 = n_tog;
      for (int k = 0; k < tbl[r].nw; k++) exp_q.push_back(tbl[r].ew[k]);
      begin_dl(tbl[r].idx);
      for (int k = 0; k < tbl[r].nb; k++) send_byte(tbl[r].ba[k], tbl[r].bd[k]);
      end_dl();
      if (tbl[r].nw > 0) wait_done($sformatf("row%0d_done", r));
      else tick(30);
      check($sformatf("row%0d_loaded", r), 64'(rom_loaded), 64'(tbl[r].exp_loaded));
      check($sformatf("row%0d_core_reset", r), 64'(core_reset), 64'(tbl[r].exp_cr));
      check($sformatf("row%0d_toggles", r), 64'(n_tog - tog0), 64'(tbl[r].nw));
      check($sformatf("row%0d_queue_empty", r), 64'(exp_q.size()), 64'(0));
`ifdef ROM_DL_CHECKSUM_EN
      if (r == 0) check("row0_checksum", 64'(checksum), 64'(16'h00AA));
`endif
    end

    // user_reset pulse in DONE appears on core_reset one cycle late
    user_reset = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk_sys);
      check($sformatf("user_reset_cyc%0d", j), 64'(core_reset), 64'(cr_pat[j]));
      tick();
      if (j == 2) user_reset = 1'b0;
    end
    check("user_reset_loaded", 64'(rom_loaded), 64'(1));

    // Ack withheld while 12 bytes stream in: 4 words fit, 2 dropped
    check("pre_overflow", 64'(overflow), 64'(0));
    hold_ack = 1'b1;
    tog0 = n_tog;
    stab_err = 0;
    for (int k = 0; k < 4; k++)
      exp_q.push_back({23'(k), 8'(8'h11 + 2 * k), 8'(8'h10 + 2 * k), 2'b11});
    begin_dl(8'd0);
    for (int k = 0; k < 12; k++) send_byte(25'(k), 8'(8'h10 + k));
    end_dl();
    tick(26);
    check("ovf_flag", 64'(overflow), 64'(1));
    check("ovf_we_held", 64'(bus.mem_we), 64'(1));
    check("ovf_a_held", 64'(bus.mem_a), 64'(0));
    check("ovf_d_held", 64'(bus.mem_d), 64'(16'h1110));
    check("ovf_stable", 64'(stab_err), 64'(0));
    hold_ack = 1'b0;
    wait_done("ovf_done");
    check("ovf_toggles", 64'(n_tog - tog0), 64'(4));
    check("ovf_queue_empty", 64'(exp_q.size()), 64'(0));
    check("ovf_sticky", 64'(overflow), 64'(1));

    // Reset while draining with a request outstanding
    hold_ack = 1'b1;
    exp_q.push_back({23'd0, 16'hA55A, 2'b11});
    begin_dl(8'd0);
    send_byte(25'd0, 8'h5A);
    send_byte(25'd1, 8'hA5);
    end_dl();
    tick(6);
    check("drain_req_high", 64'(bus.mem_req), 64'((n_tog % 2)));
    check("drain_loaded_before", 64'(rom_loaded), 64'(1));
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    reset = 1'b1;
    #1;
    check("abort_mem_req", 64'(bus.mem_req), 64'(0));
    check("abort_mem_we", 64'(bus.mem_we), 64'(0));
    check("abort_loaded", 64'(rom_loaded), 64'(0));
    check("abort_core_reset", 64'(core_reset), 64'(1));
    check("abort_overflow", 64'(overflow), 64'(0));
    tick(3);
    reset = 1'b0;
    hold_ack = 1'b0;
    tick(5);
    check("post_abort_core_reset", 64'(core_reset), 64'(1));
    check("post_abort_mem_req", 64'(bus.mem_req), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
